// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial control bus: frame layout, direction
// encodings and the slave FSM state type.
package serial_bus_pkg;

  localparam logic [2:0] START_PATTERN = 3'b111;
  localparam int         CTRL_WIDTH    = 19;

  // Frame layout, bit 18 transmitted first: {start[2:0], id[1:0], rdWr, burst, addr[11:0]}
  localparam int START_MSB    = 18;
  localparam int START_LSB    = 16;
  localparam int ID_MSB       = 15;
  localparam int ID_LSB       = 14;
  localparam int RDWR_BIT     = 13;
  localparam int BURST_BIT    = 12;
  localparam int ADDR_LSB     = 0;
  localparam int ADDR_FIELD_W = 12;

  localparam logic RDWR_READ  = 1'b0;
  localparam logic RDWR_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WR,
    RD_FETCH,
    RD_LOAD,
    RD_SEND,
    DONE
  } slaveState_t;

  function automatic logic startOk(input logic [CTRL_WIDTH-1:0] frame);
    return frame[START_MSB:START_LSB] == START_PATTERN;
  endfunction

endpackage

// File: rtl/serial_slave_if.sv
// Serial bus between one master and one slave. Write bits move on a cycle where
// valid and ready are both high; a read bit on rD is meaningful only while ready is high.
interface serial_slave_if;
  logic control;
  logic wrD;
  logic valid;
  logic last;
  logic rD;
  logic ready;
  logic busy;
  logic frameErr;

  modport master (
    output control, wrD, valid, last,
    input  rD, ready, busy, frameErr
  );

  modport slave (
    input  control, wrD, valid, last,
    output rD, ready, busy, frameErr
  );
endinterface

// File: rtl/bram.sv
// Single-port block RAM with a registered read port (one cycle latency).
module bram #(
  parameter int DEPTH      = 4096,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]      data,
  output logic [WIDTH-1:0]      q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr) mem[address] <= data;
    q <= mem[address];
  end

endmodule

// File: rtl/serial_slave.sv
// Serial bus responder: decodes control frames addressed to SLAVE_ID and moves
// words between the serial lines and the local bram.
module serial_slave
  import serial_bus_pkg::*;
#(
  parameter int         MEMORY_DEPTH = 4096,
  parameter int         DATA_WIDTH   = 16,
  parameter logic [1:0] SLAVE_ID     = 2'd0
) (
  input  logic            clk,
  input  logic            rst,
  serial_slave_if.slave   bus,
  output slaveState_t     dbgState
);

  localparam int AW = $clog2(MEMORY_DEPTH);
  localparam int CW = $clog2((CTRL_WIDTH > DATA_WIDTH) ? CTRL_WIDTH : DATA_WIDTH) + 1;

  slaveState_t           state, nextState;
  logic [CTRL_WIDTH-2:0] ctrlSh;
  logic [CTRL_WIDTH-1:0] frame;
  logic [CW-1:0]         bitCnt;
  logic [AW-1:0]         addr, wrAddr, addrInc, memAddr;
  logic                  burst, stop, stopNow, wrPend;
  logic [DATA_WIDTH-1:0] wordReg, wordFull, rdShift, wrData, memQ;
  logic                  hdrDone, wordDone, sendDone;
  logic                  rDQ, readyQ, busyQ, frameErrQ;
  logic                  rDNext, readyNext, busyNext, frameErrNext;

  assign frame    = {ctrlSh, bus.control};
  assign hdrDone  = (state == HDR) && (bitCnt == CW'(CTRL_WIDTH - 1));
  assign wordDone = (state == WR) && bus.valid && (bitCnt == CW'(DATA_WIDTH - 1));
  assign sendDone = (state == RD_SEND) && (bitCnt == CW'(DATA_WIDTH - 1));
  assign stopNow  = stop | bus.last;
  assign wordFull = {wordReg[DATA_WIDTH-2:0], bus.wrD};
  assign addrInc  = (addr == AW'(MEMORY_DEPTH - 1)) ? '0 : addr + AW'(1);
  // A pending write owns the memory port for its commit cycle.
  assign memAddr  = wrPend ? wrAddr : addr;
  assign dbgState = state;

  assign bus.rD       = rDQ;
  assign bus.ready    = readyQ;
  assign bus.busy     = busyQ;
  assign bus.frameErr = frameErrQ;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rDQ        <= 1'b0;
      readyQ     <= 1'b0;
      busyQ      <= 1'b0;
      frameErrQ  <= 1'b0;
    end else begin
      state      <= nextState;
      rDQ        <= rDNext;
      readyQ     <= readyNext;
      busyQ      <= busyNext;
      frameErrQ  <= frameErrNext;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (bus.control) nextState = HDR;
      HDR: begin
        if (hdrDone) begin
          if (!startOk(frame))                        nextState = IDLE;
          else if (frame[ID_MSB:ID_LSB] != SLAVE_ID)  nextState = IDLE;
          else if (frame[RDWR_BIT] == RDWR_WRITE)     nextState = WR;
          else                                        nextState = RD_FETCH;
        end
      end
      WR:       if (wordDone && (!burst || bus.last)) nextState = DONE;
      RD_FETCH: nextState = RD_LOAD;
      RD_LOAD:  nextState = RD_SEND;
      RD_SEND: begin
        if (sendDone) nextState = (!burst || stopNow) ? DONE : RD_FETCH;
      end
      DONE:     nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Output decode, registered above so every output comes straight from a flop
  always_comb begin
    readyNext    = (nextState == WR) || (nextState == RD_SEND);
    busyNext     = (nextState != IDLE);
    frameErrNext = hdrDone && !startOk(frame);
    rDNext       = 1'b0;
    if (state == RD_LOAD)                rDNext = memQ[DATA_WIDTH-1];
    else if (state == RD_SEND && !sendDone) rDNext = rdShift[DATA_WIDTH-2];
  end

  // Datapath: frame shifter, word assembly, read shifter, address tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlSh  <= '0;
      bitCnt  <= '0;
      addr    <= '0;
      wrAddr  <= '0;
      burst   <= 1'b0;
      stop    <= 1'b0;
      wordReg <= '0;
      rdShift <= '0;
      wrData  <= '0;
      wrPend  <= 1'b0;
    end else begin
      wrPend <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.control) begin
            ctrlSh <= (CTRL_WIDTH-1)'(1);
            bitCnt <= CW'(1);
            stop   <= 1'b0;
          end
        end
        HDR: begin
          ctrlSh <= {ctrlSh[CTRL_WIDTH-3:0], bus.control};
          bitCnt <= bitCnt + CW'(1);
          if (hdrDone) begin
            bitCnt <= '0;
            addr   <= frame[ADDR_LSB +: AW];
            burst  <= frame[BURST_BIT];
            stop   <= 1'b0;
          end
        end
        WR: begin
          if (bus.valid) begin
            wordReg <= wordFull;
            bitCnt  <= bitCnt + CW'(1);
          end
          if (wordDone) begin
            bitCnt <= '0;
            wrPend <= 1'b1;
            wrData <= wordFull;
            wrAddr <= addr;
            addr   <= addrInc;
          end
        end
        RD_LOAD: begin
          rdShift <= memQ;
          bitCnt  <= '0;
        end
        RD_SEND: begin
          rdShift <= rdShift << 1;
          bitCnt  <= bitCnt + CW'(1);
          if (bus.last) stop <= 1'b1;
          if (sendDone) begin
            bitCnt <= '0;
            if (burst && !stopNow) addr <= addrInc;
          end
        end
        default: ;
      endcase
    end
  end

  bram #(
    .DEPTH (MEMORY_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) uMem (
    .clk     (clk),
    .wr      (wrPend),
    .address (memAddr),
    .data    (wrData),
    .q       (memQ)
  );

endmodule

// File: tb/tb_serial_slave.sv
// Directed bench for serial_slave (SLAVE_ID=1): single-word table, then burst,
// wrap and mid-transaction reset sequences.
module tb_serial_slave;
  import serial_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  slaveState_t dbgState;

  serial_slave_if bus();

  serial_slave #(
    .MEMORY_DEPTH (4096),
    .DATA_WIDTH   (16),
    .SLAVE_ID     (2'd1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int readyHigh;
  int readyLow;

  typedef struct {
    logic        isRead;
    logic [2:0]  start;
    logic [1:0]  id;
    logic [11:0] addr;
    logic [15:0] data;       // write data, or expected read data
    logic        expAccept;
    logic        expErr;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic sampleReady();
    if (bus.ready === 1'b1) readyHigh++;
    else                    readyLow++;
  endtask

  task automatic sendFrame(input logic [2:0] start, input logic [1:0] id, input logic rdWr,
                           input logic burst, input logic [11:0] addr);
    logic [18:0] f;
    f = {start, id, rdWr, burst, addr};
    for (int i = 18; i >= 0; i--) begin
      bus.control = f[i];
      tick();
    end
    bus.control = 1'b0;
  endtask

  // gapAt: bit index preceded by two valid=0 cycles; lastAt: bit index carrying last
  task automatic sendBits(input logic [15:0] data, input int gapAt, input int lastAt);
    for (int i = 15; i >= 0; i--) begin
      if (i == gapAt) begin
        repeat (2) begin
          bus.valid = 1'b0;
          bus.last  = 1'b0;
          sampleReady();
          tick();
        end
      end
      bus.wrD   = data[i];
      bus.valid = 1'b1;
      bus.last  = (i == lastAt);
      sampleReady();
      tick();
    end
    bus.valid = 1'b0;
    bus.last  = 1'b0;
    bus.wrD   = 1'b0;
  endtask

  task automatic doWrite(input string name, input vec_t v);
    sendFrame(v.start, v.id, 1'b1, 1'b0, v.addr);
    check($sformatf("%s frameErr", name), bus.frameErr, v.expErr);
    check($sformatf("%s busy", name), bus.busy, v.expAccept);
    if (v.expErr) begin
      tick();
      check($sformatf("%s frameErrPulse", name), bus.frameErr, 1'b0);
    end
    readyHigh = 0;
    readyLow  = 0;
    sendBits(v.data, -1, -1);
    check($sformatf("%s readyCycles", name), readyHigh, v.expAccept ? 16 : 0);
    if (v.expAccept) begin
      check($sformatf("%s doneReady", name), bus.ready, 1'b0);
      check($sformatf("%s doneBusy", name), bus.busy, 1'b1);
      tick();
    end
    check($sformatf("%s idleBusy", name), bus.busy, 1'b0);
  endtask

  task automatic doRead(input string name, input logic [11:0] addr, input logic burst,
                        input int nWords, input logic [15:0] e0, input logic [15:0] e1);
    logic [15:0] got;
    sendFrame(3'b111, 2'd1, 1'b0, burst, addr);
    for (int w = 0; w < nWords; w++) begin
      readyHigh = 0;
      readyLow  = 0;
      check($sformatf("%s w%0d gapBusy", name, w), bus.busy, 1'b1);
      repeat (2) begin
        sampleReady();
        tick();
      end
      check($sformatf("%s w%0d gapReady", name, w), readyLow, 2);
      readyHigh = 0;
      got = '0;
      for (int i = 0; i < 16; i++) begin
        sampleReady();
        got = {got[14:0], bus.rD};
        bus.last = burst && (w == nWords - 1) && (i == 4);
        tick();
      end
      bus.last = 1'b0;
      check($sformatf("%s w%0d data", name, w), got, (w == 0) ? e0 : e1);
      check($sformatf("%s w%0d readyCycles", name, w), readyHigh, 16);
    end
    check($sformatf("%s doneReady", name), bus.ready, 1'b0);
    check($sformatf("%s doneBusy", name), bus.busy, 1'b1);
    tick();
    check($sformatf("%s idleBusy", name), bus.busy, 1'b0);
    check($sformatf("%s idleReady", name), bus.ready, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bad;
    bus.control = 1'b0;
    bus.wrD     = 1'b0;
    bus.valid   = 1'b0;
    bus.last    = 1'b0;

    vecs[0] = '{1'b0, 3'b111, 2'd1, 12'h005, 16'hA5C3, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 3'b111, 2'd1, 12'h005, 16'hA5C3, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 3'b111, 2'd2, 12'h005, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 3'b111, 2'd1, 12'h005, 16'hA5C3, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 3'b110, 2'd1, 12'h005, 16'h0F0F, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 3'b111, 2'd1, 12'h007, 16'h1234, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 3'b111, 2'd1, 12'h007, 16'h1234, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst ready", bus.ready, 1'b0);
    check("rst busy", bus.busy, 1'b0);
    check("rst frameErr", bus.frameErr, 1'b0);
    check("rst rD", bus.rD, 1'b0);
    check("rst state", dbgState, IDLE);
    rst = 1'b0;
    tick();
    check("post-rst busy", bus.busy, 1'b0);

    for (int k = 0; k < 7; k++) begin
      if (vecs[k].isRead) doRead($sformatf("vec%0d", k), vecs[k].addr, 1'b0, 1, vecs[k].data, 16'h0);
      else                doWrite($sformatf("vec%0d", k), vecs[k]);
      repeat (2) tick();
    end

    // Burst write across the top of memory, with gaps and a stray mid-word last
    sendFrame(3'b111, 2'd1, 1'b1, 1'b1, 12'hFFF);
    readyHigh = 0;
    readyLow  = 0;
    sendBits(16'h1111, 8, -1);
    sendBits(16'h2222, 3, 5);
    sendBits(16'h3333, -1, 0);
    check("bwr readyHigh", readyHigh, 52);
    check("bwr readyLow", readyLow, 0);
    check("bwr doneReady", bus.ready, 1'b0);
    check("bwr doneBusy", bus.busy, 1'b1);
    tick();
    check("bwr idleBusy", bus.busy, 1'b0);
    repeat (2) tick();

    doRead("rdFFF", 12'hFFF, 1'b0, 1, 16'h1111, 16'h0);
    repeat (2) tick();
    doRead("burstRd0", 12'h000, 1'b1, 2, 16'h2222, 16'h3333);
    repeat (2) tick();
    doRead("burstRdWrap", 12'hFFF, 1'b1, 2, 16'h1111, 16'h2222);
    repeat (2) tick();

    // Reset on write bit 8 must abort without touching memory[7]
    sendFrame(3'b111, 2'd1, 1'b1, 1'b0, 12'h007);
    for (int i = 15; i >= 8; i--) begin
      bus.wrD   = 1'b1;
      bus.valid = 1'b1;
      if (i == 8) rst = 1'b1;
      tick();
    end
    rst       = 1'b0;
    bus.valid = 1'b0;
    bus.wrD   = 1'b0;
    check("abort ready", bus.ready, 1'b0);
    check("abort busy", bus.busy, 1'b0);
    check("abort frameErr", bus.frameErr, 1'b0);
    check("abort rD", bus.rD, 1'b0);
    check("abort state", dbgState, IDLE);
    tick();
    doRead("abortRd7", 12'h007, 1'b0, 1, 16'h1234, 16'h0);

    // Unaddressed frame after everything: still ignored
    bad = '{1'b0, 3'b111, 2'd0, 12'h007, 16'hDEAD, 1'b0, 1'b0};
    doWrite("otherId", bad);
    doRead("finalRd7", 12'h007, 1'b0, 1, 16'h1234, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
